melody_player: RTL and testbench

Parametrised square-wave melody sequencer for the plant-monitor speaker path. It replaces hard-coded per-song alarm modules with one programmable engine. Each step holds a half-period, in clock cycles, and a duration, in ticks. The host loads steps through a write port, and the block plays them once or in a loop with an optional silent gap between repetitions. The alarm condition logic drives `enable`; `tone` goes straight to the speaker pin.

---
 rtl/melody_player.sv | 202 ++++++++++++++++++++
 tb/tb_melody_player.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
// Programmable square-wave melody sequencer for the speaker path.
// Plays stored {half-period, duration} steps once or in a loop.
module melody_player #(
    parameter int  NOTES    = 32,
    parameter int  HP_W     = 20,
    parameter int  DUR_W    = 16,
    parameter int  TICK_DIV = 50_000,
    parameter int  GAP_W    = 16,
    localparam int AW       = $clog2(NOTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode_loop,
    input  logic             octave_down,
    input  logic [AW:0]      seq_len,
    input  logic [GAP_W-1:0] gap_ticks,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [HP_W-1:0]  wr_half,
    input  logic [DUR_W-1:0] wr_dur,
    output logic             tone,
    output logic             busy,
    output logic [AW-1:0]    step,
    output logic             done
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, HOLD} state_t;

    state_t state, state_n;

    logic [HP_W+DUR_W-1:0] mem [NOTES];

    logic [AW-1:0]    step_r, step_n;
    logic [HP_W:0]    cur_half, cur_half_n;
    logic [HP_W:0]    half_cnt, half_cnt_n;
    logic [DUR_W-1:0] cur_dur, cur_dur_n;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [PW-1:0]    presc, presc_n;
    logic             tone_r, tone_n;
    logic             done_r, done_n;

    logic             tick;
    logic             enter;
    logic [AW-1:0]    enter_idx;
    logic [AW:0]      eff_len;
    logic [AW:0]      last_idx;
    logic [HP_W-1:0]  rd_half;
    logic [DUR_W-1:0] rd_dur;

    // Step memory: host writes land on the edge, so an entry on the
    // same edge still latches the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {wr_half, wr_dur};
    end

    assign {rd_half, rd_dur} = mem[enter_idx];

    assign tick = (presc == PW'(TICK_DIV - 1));

    // Clamp the requested length into 1..NOTES.
    always_comb begin
        if (seq_len == '0)
            eff_len = (AW+1)'(1);
        else if (seq_len > (AW+1)'(NOTES))
            eff_len = (AW+1)'(NOTES);
        else
            eff_len = seq_len;
        last_idx = eff_len - (AW+1)'(1);
    end

    // Next-state and datapath; enable low overrides everything.
    always_comb begin
        state_n    = state;
        step_n     = step_r;
        cur_half_n = cur_half;
        cur_dur_n  = cur_dur;
        half_cnt_n = half_cnt;
        dur_cnt_n  = dur_cnt;
        gap_cnt_n  = gap_cnt;
        presc_n    = presc;
        tone_n     = tone_r;
        done_n     = 1'b0;
        enter      = 1'b0;
        enter_idx  = '0;

        if (!enable) begin
            state_n    = IDLE;
            step_n     = '0;
            cur_half_n = '0;
            cur_dur_n  = '0;
            half_cnt_n = '0;
            dur_cnt_n  = '0;
            gap_cnt_n  = '0;
            presc_n    = '0;
            tone_n     = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    enter = 1'b1;
                end
                PLAY: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (cur_half == '0) begin
                        tone_n     = 1'b0;
                        half_cnt_n = '0;
                    end else if (half_cnt == cur_half - (HP_W+1)'(1)) begin
                        half_cnt_n = '0;
                        tone_n     = ~tone_r;
                    end else begin
                        half_cnt_n = half_cnt + (HP_W+1)'(1);
                    end
                    if (tick) begin
                        if (dur_cnt + DUR_W'(1) >= cur_dur) begin
                            if (step_r < last_idx[AW-1:0]) begin
                                enter     = 1'b1;
                                enter_idx = step_r + AW'(1);
                            end else if (!mode_loop) begin
                                state_n    = HOLD;
                                done_n     = 1'b1;
                                tone_n     = 1'b0;
                                half_cnt_n = '0;
                                dur_cnt_n  = '0;
                                presc_n    = '0;
                            end else if (gap_ticks == '0) begin
                                enter = 1'b1;
                            end else begin
                                state_n    = GAP;
                                tone_n     = 1'b0;
                                half_cnt_n = '0;
                                dur_cnt_n  = '0;
                                gap_cnt_n  = '0;
                                presc_n    = '0;
                            end
                        end else begin
                            dur_cnt_n = dur_cnt + DUR_W'(1);
                        end
                    end
                end
                GAP: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    tone_n  = 1'b0;
                    if (tick) begin
                        if (gap_cnt + GAP_W'(1) >= gap_ticks)
                            enter = 1'b1;
                        else
                            gap_cnt_n = gap_cnt + GAP_W'(1);
                    end
                end
                HOLD: begin
                    tone_n = 1'b0;
                end
            endcase
        end

        if (enter) begin
            state_n    = PLAY;
            step_n     = enter_idx;
            cur_half_n = octave_down ? {rd_half, 1'b0} : {1'b0, rd_half};
            cur_dur_n  = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            half_cnt_n = '0;
            dur_cnt_n  = '0;
            gap_cnt_n  = '0;
            presc_n    = '0;
            tone_n     = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_r   <= '0;
            cur_half <= '0;
            cur_dur  <= '0;
            half_cnt <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
            presc    <= '0;
            tone_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            step_r   <= step_n;
            cur_half <= cur_half_n;
            cur_dur  <= cur_dur_n;
            half_cnt <= half_cnt_n;
            dur_cnt  <= dur_cnt_n;
            gap_cnt  <= gap_cnt_n;
            presc    <= presc_n;
            tone_r   <= tone_n;
            done_r   <= done_n;
        end
    end

    assign tone = tone_r;
    assign busy = (state == PLAY) || (state == GAP);
    assign step = step_r;
    assign done = done_r;
endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: time-since-entry reference model,
// directed literal scenarios, then randomized play.
module tb_melody_player;
    localparam int NOTES = 5;
    localparam int TD    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       mode_loop = 1'b0;
    logic       octave_down = 1'b0;
    logic [3:0] seq_len = '0;
    logic [2:0] gap_ticks = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_half = '0;
    logic [3:0] wr_dur = '0;
    logic       tone;
    logic       busy;
    logic [2:0] step;
    logic       done;

    int checks = 0;
    int errors = 0;

    melody_player #(
        .NOTES(NOTES), .HP_W(8), .DUR_W(4), .TICK_DIV(TD), .GAP_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .mode_loop(mode_loop), .octave_down(octave_down),
        .seq_len(seq_len), .gap_ticks(gap_ticks),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_half(wr_half), .wr_dur(wr_dur),
        .tone(tone), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 play, 2 gap, 3 hold; mt = cycles since entry.
    int ms = 0, mstep = 0, mt = 0, mhalf = 0, mdur = 0, mdone = 0;
    int mh[NOTES];
    int md[NOTES];

    function automatic int eff(input int s);
        if (s < 1) return 1;
        if (s > NOTES) return NOTES;
        return s;
    endfunction

    task automatic menter(input int i);
        ms    = 1;
        mstep = i;
        mhalf = octave_down ? 2 * mh[i] : mh[i];
        mdur  = (md[i] < 1) ? 1 : md[i];
        mt    = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms = 0; mstep = 0; mt = 0; mhalf = 0; mdur = 0; mdone = 0;
        end else begin
            mdone = 0;
            if (!enable) begin
                ms = 0; mstep = 0; mt = 0;
            end else begin
                case (ms)
                    0: menter(0);
                    1: begin
                        mt++;
                        if (mt == mdur * TD) begin
                            if (mstep < eff(int'(seq_len)) - 1) menter(mstep + 1);
                            else if (!mode_loop) begin ms = 3; mdone = 1; end
                            else if (gap_ticks == 0) menter(0);
                            else begin ms = 2; mt = 0; end
                        end
                    end
                    2: begin
                        mt++;
                        if (mt >= int'(gap_ticks) * TD) menter(0);
                    end
                    default: ;
                endcase
            end
            if (wr_en) begin
                mh[wr_addr] = int'(wr_half);
                md[wr_addr] = int'(wr_dur);
            end
        end
    end

    // Every cycle out of reset, DUT outputs must equal the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("tone", int'(tone),
                  (ms == 1 && mhalf != 0) ? (mt / mhalf) % 2 : 0);
            check("busy", int'(busy), (ms == 1 || ms == 2) ? 1 : 0);
            check("step", int'(step), mstep);
            check("done", int'(done), mdone);
        end
    end

    logic       tr_tone[128];
    logic       tr_busy[128];
    logic       tr_done[128];
    logic [2:0] tr_step[128];

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) wr_en = 1'b0;
            tr_tone[k] = tone;
            tr_busy[k] = busy;
            tr_done[k] = done;
            tr_step[k] = step;
        end
    endtask

    task automatic wr(input int a, input int h, input int d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_half = 8'(h);
        wr_dur  = 4'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start();
        enable = 1'b1;
        @(negedge clk);
    endtask

    int cnt;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tone", int'(tone), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step", int'(step), 0);
        check("rst_done", int'(done), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NOTES; i++) wr(i, 1, 1);

        // One-shot {3,2},{5,1}
        wr(0, 3, 2); wr(1, 5, 1);
        seq_len = 4'd2; mode_loop = 1'b0;
        start();
        capture(61);
        check("os_busy0", int'(tr_busy[0]), 1);
        check("os_tone2", int'(tr_tone[2]), 0);
        check("os_tone3", int'(tr_tone[3]), 1);
        check("os_tone6", int'(tr_tone[6]), 0);
        check("os_step20", int'(tr_step[20]), 1);
        check("os_tone24", int'(tr_tone[24]), 0);
        check("os_tone25", int'(tr_tone[25]), 1);
        check("os_done29", int'(tr_done[29]), 0);
        check("os_done30", int'(tr_done[30]), 1);
        check("os_busy30", int'(tr_busy[30]), 0);
        cnt = 0;
        for (int k = 0; k < 61; k++) cnt += int'(tr_done[k]);
        check("os_done_cnt", cnt, 1);
        check("os_no_replay", int'(tr_busy[60]), 0);
        go_idle();

        // Rest then octave-down
        wr(0, 0, 1); wr(1, 4, 1);
        octave_down = 1'b1;
        start();
        capture(25);
        cnt = 0;
        for (int k = 0; k < 10; k++) cnt += int'(tr_tone[k]);
        check("rest_silent", cnt, 0);
        check("oct_tone17", int'(tr_tone[17]), 0);
        check("oct_tone18", int'(tr_tone[18]), 1);
        octave_down = 1'b0;
        go_idle();

        // Write on entry cycle ignored, write to next step seen
        wr(0, 2, 1); wr(1, 3, 1);
        enable = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_half = 8'd7; wr_dur = 4'd1;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_half = 8'd6; wr_dur = 4'd1;
        capture(25);
        check("entry_wr1", int'(tr_tone[1]), 0);
        check("entry_wr2", int'(tr_tone[2]), 1);
        check("next_wr13", int'(tr_tone[13]), 0);
        check("next_wr16", int'(tr_tone[16]), 1);
        check("next_wr_done", int'(tr_done[20]), 1);
        go_idle();

        // Loop with gap
        wr(0, 3, 2);
        seq_len = 4'd1; mode_loop = 1'b1; gap_ticks = 3'd2;
        start();
        capture(100);
        cnt = 0;
        for (int k = 0; k < 100; k++) cnt += int'(tr_done[k]);
        check("loop_no_done", cnt, 0);
        cnt = 0;
        for (int k = 0; k < 100; k++) cnt += int'(tr_busy[k]);
        check("loop_busy", cnt, 100);
        check("loop_gap_tone", int'(tr_tone[25]), 0);
        check("loop_gap_step", int'(tr_step[30]), 0);
        check("loop_rep_tone42", int'(tr_tone[42]), 0);
        check("loop_rep_tone43", int'(tr_tone[43]), 1);

        // Abort mid-step, then restart
        repeat (7) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_tone", int'(tone), 0);
        start();
        repeat (45) @(negedge clk);
        go_idle();

        // Length clamps and dur 0
        mode_loop = 1'b0;
        wr(0, 1, 0);
        for (int i = 1; i < NOTES; i++) wr(i, 2, 1);
        seq_len = 4'd0;
        start();
        capture(15);
        check("len0_done", int'(tr_done[10]), 1);
        go_idle();
        seq_len = 4'(NOTES + 5);
        start();
        capture(55);
        check("lenmax_step", int'(tr_step[40]), 4);
        check("lenmax_done", int'(tr_done[50]), 1);
        go_idle();

        // Async reset between edges
        start();
        repeat (25) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tone", int'(tone), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_step", int'(step), 0);
        check("arst_done", int'(done), 0);
        enable = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", int'(busy), 0);

        // Randomized play
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            wr_en       = ($urandom_range(0, 3) == 0);
            wr_addr     = 3'($urandom_range(0, NOTES - 1));
            wr_half     = 8'($urandom_range(0, 6));
            wr_dur      = 4'($urandom_range(0, 3));
            octave_down = 1'($urandom_range(0, 1));
            if (enable) begin
                if ($urandom_range(0, 199) == 0) enable = 1'b0;
            end else begin
                seq_len   = 4'($urandom_range(0, 15));
                mode_loop = 1'($urandom_range(0, 1));
                gap_ticks = 3'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) enable = 1'b1;
            end
        end
        wr_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
